// File: rtl/kbd_pkg.sv
// Shared constants, state encoding and row actions for the keypad RGB controller.
// apply_act is the one place where a channel level is stepped, set or cleared.
package kbd_pkg;

   localparam int SCAN_TICKS_DEF     = 25000;
   localparam int DEBOUNCE_SCANS_DEF = 8;
   localparam int STEP_DEF           = 16;

   localparam int NUM_COLS = 3;
   localparam int NUM_ROWS = 4;

   typedef enum logic [1:0] {
      ST_SETTLE  = 2'd0,
      ST_SAMPLE  = 2'd1,
      ST_ADVANCE = 2'd2
   } scan_state_t;

   // The row index doubles as the action code.
   typedef enum logic [1:0] {
      ACT_INC  = 2'd0,
      ACT_DEC  = 2'd1,
      ACT_MAX  = 2'd2,
      ACT_ZERO = 2'd3
   } row_act_t;

   localparam logic [1:0] CH_R = 2'd0;
   localparam logic [1:0] CH_G = 2'd1;
   localparam logic [1:0] CH_B = 2'd2;

   // Nine-bit arithmetic: bit 8 flags overflow on INC and borrow on DEC.
   function automatic logic [7:0] apply_act(input logic [7:0] val,
                                            input row_act_t   act,
                                            input logic [7:0] step);
      logic [8:0] w_wide;
      logic [7:0] w_res;
      w_wide = 9'd0;
      w_res  = val;
      case (act)
         ACT_INC: begin
            w_wide = {1'b0, val} + {1'b0, step};
            w_res  = w_wide[8] ? 8'hFF : w_wide[7:0];
         end
         ACT_DEC: begin
            w_wide = {1'b0, val} - {1'b0, step};
            w_res  = w_wide[8] ? 8'h00 : w_wide[7:0];
         end
         ACT_MAX: w_res = 8'hFF;
         default: w_res = 8'h00;
      endcase
      return w_res;
   endfunction

endpackage

// File: rtl/key_debounce.sv
// Debounce for one key: the stable state flips after DEBOUNCE_SCANS consecutive
// disagreeing samples; o_press pulses combinationally on the sample that flips 0->1.
module key_debounce
   import kbd_pkg::*;
#(
   parameter int DEBOUNCE_SCANS = DEBOUNCE_SCANS_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_sample_en,
   input  logic i_raw,
   output logic o_press
);

   logic [3:0] r_cnt;
   logic       r_stable;
   logic       w_differs;
   logic       w_flip;

   assign w_differs = (i_raw != r_stable);
   assign w_flip    = i_sample_en && w_differs && (r_cnt == 4'(DEBOUNCE_SCANS - 1));
   assign o_press   = w_flip && i_raw;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cnt    <= 4'd0;
         r_stable <= 1'b0;
      end else if (i_sample_en) begin
         if (!w_differs) begin
            r_cnt <= 4'd0;
         end else if (w_flip) begin
            r_stable <= i_raw;
            r_cnt    <= 4'd0;
         end else begin
            r_cnt <= r_cnt + 4'd1;
         end
      end
   end

endmodule

// File: rtl/keypad_rgb_ctrl.sv
// 3x4 keypad scanner driving three 8-bit RGB duty levels.
// Valid/ready is not used here: key_event is a single-cycle strobe qualifying key_code and data.
module keypad_rgb_ctrl
   import kbd_pkg::*;
#(
   parameter int SCAN_TICKS     = SCAN_TICKS_DEF,
   parameter int DEBOUNCE_SCANS = DEBOUNCE_SCANS_DEF,
   parameter int STEP           = STEP_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  col_data,
   output logic [2:0]  col_power,
   output logic [23:0] data,
   output logic        key_event,
   output logic [3:0]  key_code
);

   localparam int              CNT_W     = $clog2(SCAN_TICKS);
   localparam logic [CNT_W-1:0] SAMPLE_AT = CNT_W'(SCAN_TICKS - 2);
   localparam logic [7:0]      STEP_8    = 8'(STEP);

   logic [3:0]       r_sync1;
   logic [3:0]       r_sync2;
   scan_state_t      r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [1:0]       r_col;
   logic [2:0]       r_col_power;
   logic [23:0]      r_data;
   logic             r_key_event;
   logic [3:0]       r_key_code;

   logic                       w_sample_en;
   logic [NUM_COLS*NUM_ROWS-1:0] w_press;
   logic [NUM_ROWS-1:0]        w_col_press;
   logic                       w_any;
   logic [1:0]                 w_row;
   row_act_t                   w_act;
   logic [7:0]                 w_cur;
   logic [7:0]                 w_new;

   assign w_sample_en = (r_state == ST_SAMPLE);

   for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
      for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
         key_debounce #(
            .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
         ) u_key (
            .clk         (clk),
            .rst_n       (rst_n),
            .i_sample_en (w_sample_en && (r_col == 2'(c))),
            .i_raw       (r_sync2[r]),
            .o_press     (w_press[c*NUM_ROWS + r])
         );
      end
   end

   // Only the sampled column can press, so OR-ing columns yields that column's rows.
   assign w_col_press = w_press[3:0] | w_press[7:4] | w_press[11:8];
   assign w_any       = |w_col_press;

   always_comb begin
      w_row = 2'd0;
      if (w_col_press[3])      w_row = 2'd3;
      else if (w_col_press[2]) w_row = 2'd2;
      else if (w_col_press[1]) w_row = 2'd1;
   end

   assign w_act = row_act_t'(w_row);

   always_comb begin
      case (r_col)
         CH_R:    w_cur = r_data[7:0];
         CH_G:    w_cur = r_data[15:8];
         default: w_cur = r_data[23:16];
      endcase
   end

   assign w_new = apply_act(w_cur, w_act, STEP_8);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_sync1     <= 4'd0;
         r_sync2     <= 4'd0;
         r_state     <= ST_SETTLE;
         r_cnt       <= '0;
         r_col       <= 2'd0;
         r_col_power <= 3'b001;
         r_data      <= 24'h000000;
         r_key_event <= 1'b0;
         r_key_code  <= 4'd0;
      end else begin
         r_sync1     <= col_data;
         r_sync2     <= r_sync1;
         r_key_event <= 1'b0;
         case (r_state)
            ST_SETTLE: begin
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == SAMPLE_AT) r_state <= ST_SAMPLE;
            end
            ST_SAMPLE: begin
               r_state <= ST_ADVANCE;
               if (w_any) begin
                  r_key_event <= 1'b1;
                  r_key_code  <= {r_col, w_row};
                  case (r_col)
                     CH_R:    r_data[7:0]   <= w_new;
                     CH_G:    r_data[15:8]  <= w_new;
                     default: r_data[23:16] <= w_new;
                  endcase
               end
            end
            ST_ADVANCE: begin
               r_cnt       <= '0;
               r_state     <= ST_SETTLE;
               r_col_power <= {r_col_power[1:0], r_col_power[2]};
               r_col       <= (r_col == CH_B) ? CH_R : r_col + 2'd1;
            end
            default: r_state <= ST_SETTLE;
         endcase
      end
   end

   assign col_power = r_col_power;
   assign data      = r_data;
   assign key_event = r_key_event;
   assign key_code  = r_key_code;

endmodule
